fpu_div_scheduler: RTL

- Shares one multi-cycle FPU divider among NREQ requesters.
- Round-robin arbitration selects one request at a time.
- Operands are latched, the divider is started and its done flag is awaited. A watchdog aborts a hung operation.
- The result is returned with the requester ID over a valid/ready response channel. Sits between the issue logic of the FP lanes and the single shared divider instance.

---
 rtl/fpu_div_scheduler_if.sv | 34 +++
 rtl/fpu_div_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fpu_div_scheduler_if.sv
// Bundle of requester, divider and response signals for fpu_div_scheduler.
// The master modport is the scheduler side; slave is the surrounding logic.
interface fpu_div_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [31:0]        div_a;
    logic [31:0]        div_b;
    logic               div_start;
    logic               div_done;
    logic [31:0]        div_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_timeout;
    logic               busy;

    modport master (
        input  req_valid, req_a, req_b, div_done, div_result, rsp_ready,
        output req_ready, div_a, div_b, div_start, rsp_valid, rsp_data,
               rsp_id, rsp_timeout, busy
    );

    modport slave (
        output req_valid, req_a, req_b, div_done, div_result, rsp_ready,
        input  req_ready, div_a, div_b, div_start, rsp_valid, rsp_data,
               rsp_id, rsp_timeout, busy
    );
endinterface

// File: rtl/fpu_div_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP divider, with a watchdog.
// Optional FPU_DIV_BYPASS_EN: zero/zero-divisor operands answered without the divider.
module fpu_div_scheduler #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    fpu_div_scheduler_if.master bus
);
    localparam int              CW      = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [31:0]     div_a_q, div_b_q, rsp_data_q;
    logic            div_start_q, rsp_valid_q, rsp_timeout_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  ptr_d;
    logic [IDW:0]    cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[32*gi +: 32];
        assign b_arr[gi] = bus.req_b[32*gi +: 32];
    end

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign cnt_d = cnt_q + 1'b1;

    // Grant is combinational and only offered from IDLE outside of reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && grant_found)
            bus.req_ready[grant_idx] = 1'b1;
    end

`ifdef FPU_DIV_BYPASS_EN
    logic        byp_hit;
    logic [31:0] byp_data;
    logic [31:0] byp_a, byp_b;
    logic        byp_sgn;

    always_comb begin
        byp_a    = a_arr[grant_idx];
        byp_b    = b_arr[grant_idx];
        byp_sgn  = byp_a[31] ^ byp_b[31];
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_b[30:0] == '0) begin
            byp_hit  = 1'b1;
            byp_data = (byp_a[30:0] == '0) ? QNAN : {byp_sgn, 31'h7F800000};
        end else if (byp_a[30:0] == '0) begin
            byp_hit  = 1'b1;
            byp_data = {byp_sgn, 31'h0};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            div_a_q       <= '0;
            div_b_q       <= '0;
            div_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        div_a_q  <= a_arr[grant_idx];
                        div_b_q  <= b_arr[grant_idx];
                        id_q     <= grant_idx;
                        rr_ptr_q <= ptr_d;
`ifdef FPU_DIV_BYPASS_EN
                        if (byp_hit) begin
                            rsp_data_q    <= byp_data;
                            rsp_timeout_q <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
`else
                        div_start_q <= 1'b1;
                        state_q     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    // Done wins over a coinciding watchdog expiry.
                    if (bus.div_done) begin
                        rsp_data_q    <= bus.div_result;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (cnt_d == TO_LAST) begin
                        rsp_data_q    <= QNAN;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.div_start   = div_start_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
